// File: rtl/mul_issue_queue.sv
// Operand FIFO and issue controller for an iterative multiplier: queues operand pairs,
// issues one at a time as a single-cycle start pulse and holds the product until taken.
module mul_issue_queue #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 32
) (
  input  logic                         clk_i,
  input  logic                         rst_ni,
  input  logic                         in_valid_i,
  output logic                         in_ready_o,
  input  logic [Width-1:0]             in_a_i,
  input  logic [Width-1:0]             in_b_i,
  output logic                         mul_valid_in_o,
  output logic [Width-1:0]             mul_a_o,
  output logic [Width-1:0]             mul_b_o,
  input  logic                         mul_valid_out_i,
  input  logic [2*Width-1:0]           mul_r_i,
  output logic                         out_valid_o,
  input  logic                         out_ready_i,
  output logic [2*Width-1:0]           out_r_o,
  output logic [$clog2(Depth):0]       count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StHold  = 2'd3;

  logic [2*Width-1:0] mem_q [Depth];
  logic [PtrW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]    count_q, count_d;
  logic [1:0]         state_q, state_d;
  logic               mul_valid_q;
  logic [Width-1:0]   mul_a_q, mul_b_q;
  logic               out_valid_q, out_valid_d;
  logic [2*Width-1:0] out_r_q, out_r_d;
  logic               push, pop;
  logic [2*Width-1:0] head;

  assign in_ready_o     = (count_q != CntW'(Depth));
  assign push           = in_valid_i && in_ready_o;
  assign head           = mem_q[rd_ptr_q];
  assign mul_valid_in_o = mul_valid_q;
  assign mul_a_o        = mul_a_q;
  assign mul_b_o        = mul_b_q;
  assign out_valid_o    = out_valid_q;
  assign out_r_o        = out_r_q;
  assign count_o        = count_q;

  // mul_valid_out_i is only looked at in StWait; in StIssue it may still be stale.
  always_comb begin
    state_d     = state_q;
    pop         = 1'b0;
    out_valid_d = out_valid_q;
    out_r_d     = out_r_q;
    case (state_q)
      StIdle: begin
        if (count_q != '0) begin
          pop     = 1'b1;
          state_d = StIssue;
        end
      end
      StIssue: state_d = StWait;
      StWait: begin
        if (mul_valid_out_i) begin
          out_r_d     = mul_r_i;
          out_valid_d = 1'b1;
          state_d     = StHold;
        end
      end
      StHold: begin
        if (out_ready_i) begin
          out_valid_d = 1'b0;
          if (count_q != '0) begin
            pop     = 1'b1;
            state_d = StIssue;
          end else begin
            state_d = StIdle;
          end
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= {in_a_i, in_b_i};
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      mul_valid_q <= 1'b0;
      mul_a_q     <= '0;
      mul_b_q     <= '0;
      out_valid_q <= 1'b0;
      out_r_q     <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      mul_valid_q <= pop;
      out_valid_q <= out_valid_d;
      out_r_q     <= out_r_d;
      if (push) begin
        wr_ptr_q <= wr_ptr_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + 1'b1;
        mul_a_q  <= head[2*Width-1:Width];
        mul_b_q  <= head[Width-1:0];
      end
    end
  end

endmodule

// File: tb/tb_mul_issue_queue.sv
// Directed bench for mul_issue_queue with a behavioural iterative multiplier model.
module tb_mul_issue_queue;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_a = '0;
  logic [31:0] in_b = '0;
  logic        mul_valid_in;
  logic [31:0] mul_a, mul_b;
  logic        mul_valid_out;
  logic [63:0] mul_r;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [63:0] out_r;
  logic [2:0]  count;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  mul_issue_queue #(.Depth(4), .Width(32)) dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .in_valid_i     (in_valid),
    .in_ready_o     (in_ready),
    .in_a_i         (in_a),
    .in_b_i         (in_b),
    .mul_valid_in_o (mul_valid_in),
    .mul_a_o        (mul_a),
    .mul_b_o        (mul_b),
    .mul_valid_out_i(mul_valid_out),
    .mul_r_i        (mul_r),
    .out_valid_o    (out_valid),
    .out_ready_i    (out_ready),
    .out_r_o        (out_r),
    .count_o        (count)
  );

  // Multiplier model: loads on start, clears done, finishes 1 + msb(a) cycles later.
  function automatic int msb(input logic [31:0] a);
    for (int i = 31; i >= 0; i--) if (a[i]) return i;
    return 0;
  endfunction

  logic [63:0] m_prod = '0;
  logic [63:0] m_r = '0;
  int          m_cnt = 0;
  logic        m_busy = 1'b0;
  logic        m_vout = 1'b0;
  assign mul_r = m_r;
  assign mul_valid_out = m_vout;

  always @(posedge clk) begin
    if (mul_valid_in) begin
      m_prod <= {32'b0, mul_a} * {32'b0, mul_b};
      m_cnt  <= msb(mul_a);
      m_busy <= 1'b1;
      m_vout <= 1'b0;
    end else if (m_busy) begin
      if (m_cnt == 0) begin
        m_vout <= 1'b1;
        m_r    <= m_prod;
        m_busy <= 1'b0;
      end else begin
        m_cnt <= m_cnt - 1;
      end
    end
  end

  int          n_issue = 0;
  int          n_outv = 0;
  logic [31:0] last_a = '0;
  logic [31:0] last_b = '0;
  logic [63:0] got[$];

  always @(posedge clk) begin
    if (rst_n) begin
      if (mul_valid_in) begin
        n_issue <= n_issue + 1;
        last_a  <= mul_a;
        last_b  <= mul_b;
      end
      if (out_valid) begin
        n_outv <= n_outv + 1;
        if (out_ready) got.push_back(out_r);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b);
    int n = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    while (!in_ready && n < 50) begin
      tick();
      n++;
    end
    total++;
    if (n >= 50) $display("FAIL push_timeout: in_ready stuck low for a=%h", a);
    else passed++;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int k);
    int n = 0;
    while (got.size() < k && n < 200) begin
      tick();
      n++;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (5) begin
      in_valid  = 1'($urandom);
      in_a      = $urandom;
      in_b      = $urandom;
      out_ready = 1'($urandom);
      tick();
    end
    total++; if (mul_valid_in !== 1'b0) $display("FAIL rst_mul_valid: got %b want 0", mul_valid_in); else passed++;
    total++; if (mul_a !== 32'd0) $display("FAIL rst_mul_a: got %h want 0", mul_a); else passed++;
    total++; if (mul_b !== 32'd0) $display("FAIL rst_mul_b: got %h want 0", mul_b); else passed++;
    total++; if (out_valid !== 1'b0) $display("FAIL rst_out_valid: got %b want 0", out_valid); else passed++;
    total++; if (out_r !== 64'd0) $display("FAIL rst_out_r: got %h want 0", out_r); else passed++;
    total++; if (in_ready !== 1'b1) $display("FAIL rst_in_ready: got %b want 1", in_ready); else passed++;
    total++; if (count !== 3'd0) $display("FAIL rst_count: got %0d want 0", count); else passed++;
    in_valid = 1'b0;
    out_ready = 1'b1;
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_single();
    int s = got.size();
    int i0 = n_issue;
    int o0 = n_outv;
    out_ready = 1'b1;
    push(32'd3, 32'd5);
    wait_got(s + 1);
    tick();
    tick();
    total++; if (got.size() != s + 1) $display("FAIL single_count: got %0d results want %0d", got.size(), s + 1); else passed++;
    total++; if (got[s] !== 64'd15) $display("FAIL single_product: got %h want 15", got[s]); else passed++;
    total++; if (n_issue - i0 != 1) $display("FAIL single_pulses: got %0d want 1", n_issue - i0); else passed++;
    total++; if (last_a !== 32'd3 || last_b !== 32'd5) $display("FAIL single_operands: got %0d,%0d want 3,5", last_a, last_b); else passed++;
    total++; if (n_outv - o0 != 1) $display("FAIL single_outv_cycles: got %0d want 1", n_outv - o0); else passed++;
    total++; if (out_valid !== 1'b0 || count !== 3'd0) $display("FAIL single_idle: out_valid %b count %0d want 0 0", out_valid, count); else passed++;
  endtask

  task automatic test_zero_max();
    int s;
    out_ready = 1'b0;
    push(32'd0, 32'hFFFF_FFFF);
    repeat (3) tick();
    total++; if (out_valid !== 1'b0) $display("FAIL zero_early: out_valid %b want 0 after 3 edges", out_valid); else passed++;
    tick();
    total++; if (out_valid !== 1'b1) $display("FAIL zero_latency: out_valid %b want 1 after 4 edges", out_valid); else passed++;
    total++; if (out_r !== 64'd0) $display("FAIL zero_product: got %h want 0", out_r); else passed++;
    out_ready = 1'b1;
    tick();
    s = got.size();
    push(32'hFFFF_FFFF, 32'hFFFF_FFFF);
    wait_got(s + 1);
    total++; if (got.size() != s + 1) $display("FAIL max_count: got %0d results want %0d", got.size(), s + 1); else passed++;
    total++; if (got[s] !== 64'hFFFF_FFFE_0000_0001) $display("FAIL max_product: got %h want fffffffe00000001", got[s]); else passed++;
    tick();
  endtask

  task automatic test_fill_wrap();
    logic [63:0] exp6 [6];
    int s = got.size();
    int n = 0;
    exp6 = '{64'd2, 64'd6, 64'd12, 64'd20, 64'd30, 64'd42};
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) push(32'(i), 32'(i + 1));
    while (!out_valid && n < 20) begin
      tick();
      n++;
    end
    repeat (3) tick();
    total++; if (count !== 3'd4) $display("FAIL fill_count: got %0d want 4", count); else passed++;
    total++; if (in_ready !== 1'b0) $display("FAIL fill_in_ready: got %b want 0", in_ready); else passed++;
    total++; if (out_valid !== 1'b1 || out_r !== 64'd2) $display("FAIL fill_hold: out_valid %b out_r %0d want 1 2", out_valid, out_r); else passed++;
    out_ready = 1'b1;
    push(32'd6, 32'd7);
    wait_got(s + 6);
    total++; if (got.size() != s + 6) $display("FAIL fill_results: got %0d results want %0d", got.size(), s + 6); else passed++;
    for (int k = 0; k < 6; k++) begin
      total++;
      if (got[s + k] !== exp6[k]) $display("FAIL fill_order_%0d: got %0d want %0d", k, got[s + k], exp6[k]);
      else passed++;
    end
    tick();
    total++; if (count !== 3'd0) $display("FAIL fill_drain_count: got %0d want 0", count); else passed++;
  endtask

  task automatic test_backpressure();
    int s = got.size();
    int i0 = n_issue;
    int i1;
    int n = 0;
    logic [63:0] ref_r;
    logic stable = 1'b1;
    out_ready = 1'b0;
    push(32'd7, 32'd9);
    push(32'd2, 32'd2);
    while (!out_valid && n < 100) begin
      tick();
      n++;
    end
    ref_r = out_r;
    i1 = n_issue;
    repeat (20) begin
      tick();
      if (out_r !== ref_r || out_valid !== 1'b1) stable = 1'b0;
    end
    total++; if (ref_r !== 64'd63) $display("FAIL bp_product: got %0d want 63", ref_r); else passed++;
    total++; if (stable !== 1'b1) $display("FAIL bp_stable: out_r/out_valid changed under backpressure, now %h", out_r); else passed++;
    total++; if (n_issue != i1 || i1 - i0 != 1) $display("FAIL bp_pulses: got %0d want 1", n_issue - i0); else passed++;
    total++; if (count !== 3'd1) $display("FAIL bp_count: got %0d want 1", count); else passed++;
    out_ready = 1'b1;
    wait_got(s + 2);
    total++; if (got.size() != s + 2 || got[s + 1] !== 64'd4) $display("FAIL bp_second: got %0d want 4", got[s + 1]); else passed++;
    tick();
  endtask

  task automatic test_reset_wait();
    int i0, o0;
    out_ready = 1'b1;
    push(32'hFFFF_FFFF, 32'd3);
    push(32'd1, 32'd1);
    push(32'd2, 32'd2);
    tick();
    tick();
    total++; if (count !== 3'd2) $display("FAIL rw_queued: got %0d want 2", count); else passed++;
    i0 = n_issue;
    o0 = n_outv;
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    total++; if (count !== 3'd0 || out_valid !== 1'b0) $display("FAIL rw_after_reset: count %0d out_valid %b want 0 0", count, out_valid); else passed++;
    repeat (60) tick();
    total++; if (mul_valid_out !== 1'b1) $display("FAIL rw_mul_done: got %b want 1", mul_valid_out); else passed++;
    total++; if (n_outv != o0) $display("FAIL rw_no_out: got %0d out_valid cycles want 0", n_outv - o0); else passed++;
    total++; if (n_issue != i0) $display("FAIL rw_no_issue: got %0d pulses want 0", n_issue - i0); else passed++;
    total++; if (count !== 3'd0 || in_ready !== 1'b1) $display("FAIL rw_idle: count %0d in_ready %b want 0 1", count, in_ready); else passed++;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_zero_max();
    test_fill_wrap();
    test_backpressure();
    test_reset_wait();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
